// File: rtl/srl_fifo_pkg.sv
// Shared constants and helpers for the SRL-based FIFO family.
package srl_fifo_pkg;

    localparam int unsigned DefDataWidth = 32;
    localparam int unsigned DefDepth     = 16;

    // Smallest r with 2**r >= value; returns 0 for value <= 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/srl_fifo_reg_out_if.sv
// Producer/consumer handshake bundle for srl_fifo_reg_out.
interface srl_fifo_reg_out_if
    import srl_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned ADDR_WIDTH = clog2(DefDepth)
) ();

    logic                  if_write;
    logic [DATA_WIDTH-1:0] if_din;
    logic                  if_full_n;
    logic                  if_read;
    logic [DATA_WIDTH-1:0] if_dout;
    logic                  if_empty_n;
    logic [ADDR_WIDTH:0]   usedw;
    logic                  almost_full;

    // Side that produces and consumes data (the FIFO's user).
    modport master (
        output if_write, if_din, if_read,
        input  if_full_n, if_dout, if_empty_n, usedw, almost_full
    );

    // The FIFO itself.
    modport slave (
        input  if_write, if_din, if_read,
        output if_full_n, if_dout, if_empty_n, usedw, almost_full
    );

endinterface

// File: rtl/srl_fifo_shiftreg.sv
// Reset-free addressable shift register; written so synthesis maps it onto SRL primitives.
module srl_fifo_shiftreg
    import srl_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned ADDR_WIDTH = clog2(DefDepth),
    parameter int unsigned DEPTH      = DefDepth
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Shift all entries one place on a write; newest word lands in entry 0.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[0] <= din;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                mem[i] <= mem[i-1];
            end
        end
    end

    assign dout = mem[addr];

endmodule

// File: rtl/srl_fifo_reg_out.sv
// SRL-storage FIFO with optional registered output stage (OUT_REG=1 adds one entry).
module srl_fifo_reg_out
    import srl_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned DEPTH      = DefDepth,
    parameter int unsigned ADDR_WIDTH = clog2(DEPTH),
    parameter int unsigned OUT_REG    = 1,
    parameter int unsigned AF_MARGIN  = 2
) (
    input logic               clk,
    input logic               reset_n,
    srl_fifo_reg_out_if.slave bus
);

    localparam int unsigned         Cap      = DEPTH + OUT_REG;
    localparam logic [ADDR_WIDTH:0] DepthCnt = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AfLevel  =
        (AF_MARGIN >= Cap) ? '0 : (ADDR_WIDTH+1)'(Cap - AF_MARGIN);
    localparam logic [ADDR_WIDTH:0] CntOne   = (ADDR_WIDTH+1)'(1);

    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic [ADDR_WIDTH:0]   usedw_q, usedw_d;
    logic                  full_n_q, full_n_d;
    logic                  empty_n_q, empty_n_d;
    logic                  af_q, af_d;
    logic                  ov_q, ov_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;

    logic                  wr_acc;
    logic                  rd_acc;
    logic                  load;
    logic                  sr_we;
    logic [ADDR_WIDTH-1:0] sr_addr;
    logic [DATA_WIDTH-1:0] sr_dout;

    assign wr_acc  = bus.if_write & full_n_q;
    assign rd_acc  = bus.if_read & empty_n_q;
    // No shifting while in reset so requests during reset leave no trace.
    assign sr_we   = wr_acc & reset_n;
    // Oldest stored word sits at count-1; park at 0 when storage is empty.
    assign sr_addr = (cnt_q == '0) ? '0 : ADDR_WIDTH'(cnt_q - CntOne);

    srl_fifo_shiftreg #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_storage (
        .clk  (clk),
        .we   (sr_we),
        .addr (sr_addr),
        .din  (bus.if_din),
        .dout (sr_dout)
    );

    // Next-state for storage count, output stage and registered flags.
    always_comb begin
        load   = 1'b0;
        ov_d   = ov_q;
        dout_d = dout_q;
        cnt_d  = cnt_q;
        if (OUT_REG != 0) begin
            // Refill the output register whenever it is free or being drained.
            load = (cnt_q != '0) && (!ov_q || rd_acc);
            if (load) begin
                ov_d   = 1'b1;
                dout_d = sr_dout;
            end else if (rd_acc) begin
                ov_d = 1'b0;
            end
            unique case ({wr_acc, load})
                2'b10:   cnt_d = cnt_q + CntOne;
                2'b01:   cnt_d = cnt_q - CntOne;
                default: cnt_d = cnt_q;
            endcase
        end else begin
            unique case ({wr_acc, rd_acc})
                2'b10:   cnt_d = cnt_q + CntOne;
                2'b01:   cnt_d = cnt_q - CntOne;
                default: cnt_d = cnt_q;
            endcase
        end
        usedw_d   = cnt_d + (ADDR_WIDTH+1)'(ov_d);
        full_n_d  = (cnt_d != DepthCnt);
        empty_n_d = (OUT_REG != 0) ? ov_d : (cnt_d != '0);
        af_d      = (usedw_d >= AfLevel);
    end

    // State register with synchronous active-low reset; storage is never cleared.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            usedw_q   <= '0;
            full_n_q  <= 1'b1;
            empty_n_q <= 1'b0;
            af_q      <= 1'b0;
            ov_q      <= 1'b0;
            dout_q    <= '0;
        end else begin
            cnt_q     <= cnt_d;
            usedw_q   <= usedw_d;
            full_n_q  <= full_n_d;
            empty_n_q <= empty_n_d;
            af_q      <= af_d;
            ov_q      <= ov_d;
            dout_q    <= dout_d;
        end
    end

    assign bus.if_full_n   = full_n_q;
    assign bus.if_empty_n  = empty_n_q;
    assign bus.usedw       = usedw_q;
    assign bus.almost_full = af_q;
    assign bus.if_dout     = (OUT_REG != 0) ? dout_q : sr_dout;

endmodule
